// File: rtl/multi_timebase_pkg.sv
// Shared definitions for the multi-channel timebase generator.
// Mode encodings and default sizing constants.
package multi_timebase_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE  = 2'b00,
    MODE_PULSE   = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  localparam int unsigned DEF_CNT_W = 32;
  localparam int unsigned DEF_TC    = 49_999_999;

endpackage

// File: rtl/timebase_channel.sv
// Single timebase channel: programmable divider producing tick, a
// mode-dependent waveform (toggle / pulse / one-shot gate) and busy.
module timebase_channel
  import multi_timebase_pkg::*;
#(
  parameter int unsigned          CNT_W      = DEF_CNT_W,
  parameter logic [CNT_W-1:0]     DEFAULT_TC = CNT_W'(DEF_TC)
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] tc_in,
  input  logic [1:0]       mode_in,
  input  logic             enable,
  input  logic             trigger,
  output logic             tick,
  output logic             wave,
  output logic             busy
);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] tc_reg;
  mode_e            mode_reg;
  logic             trig_d;
  logic             tick_nxt, wave_nxt, busy_nxt;
  logic             terminal, trig_rise;

  assign terminal  = (cnt == tc_reg);
  assign trig_rise = trigger & ~trig_d;

  always_comb begin
    cnt_nxt  = cnt;
    tick_nxt = 1'b0;
    wave_nxt = wave;
    busy_nxt = busy;
    if (load || !enable) begin
      cnt_nxt  = '0;
      wave_nxt = 1'b0;
      busy_nxt = 1'b0;
    end else begin
      unique case (mode_reg)
        MODE_ONESHOT: begin
          if (busy) begin
            if (terminal) begin
              cnt_nxt  = '0;
              busy_nxt = 1'b0;
              wave_nxt = 1'b0;
              tick_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else begin
            // Idle gate: counter parked at zero until a fresh trigger edge.
            cnt_nxt  = '0;
            wave_nxt = trig_rise;
            busy_nxt = trig_rise;
          end
        end
        MODE_PULSE: begin
          busy_nxt = 1'b0;
          wave_nxt = terminal;
          tick_nxt = terminal;
          cnt_nxt  = terminal ? '0 : cnt + CNT_W'(1);
        end
        default: begin
          busy_nxt = 1'b0;
          tick_nxt = terminal;
          wave_nxt = terminal ? ~wave : wave;
          cnt_nxt  = terminal ? '0 : cnt + CNT_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      tc_reg   <= DEFAULT_TC;
      mode_reg <= MODE_TOGGLE;
      trig_d   <= 1'b0;
      tick     <= 1'b0;
      wave     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      trig_d <= trigger;
      if (load) begin
        tc_reg   <= tc_in;
        mode_reg <= mode_e'(mode_in);
      end
      cnt  <= cnt_nxt;
      tick <= tick_nxt;
      wave <= wave_nxt;
      busy <= busy_nxt;
    end
  end

endmodule

// File: rtl/multi_timebase.sv
// N-channel timebase generator: decodes config writes into per-channel
// load strobes and instantiates one independent timer per channel.
module multi_timebase
  import multi_timebase_pkg::*;
#(
  parameter int unsigned      CHANNELS   = 4,
  parameter int unsigned      CNT_W      = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_TC = CNT_W'(DEF_TC),
  localparam int unsigned     CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                sys_clk,
  input  logic                reset_n,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_tc,
  input  logic [1:0]          cfg_mode,
  input  logic [CHANNELS-1:0] ch_enable,
  input  logic [CHANNELS-1:0] trigger,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] wave,
  output logic [CHANNELS-1:0] busy
);

  logic [CHANNELS-1:0] load;

  // Out-of-range channel numbers match no decoder, so such writes are dropped.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign load[g] = cfg_wr && (cfg_ch == CH_W'(g));

    timebase_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_TC (DEFAULT_TC)
    ) u_ch (
      .sys_clk (sys_clk),
      .reset_n (reset_n),
      .load    (load[g]),
      .tc_in   (cfg_tc),
      .mode_in (cfg_mode),
      .enable  (ch_enable[g]),
      .trigger (trigger[g]),
      .tick    (tick[g]),
      .wave    (wave[g]),
      .busy    (busy[g])
    );
  end

endmodule
